// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the instruction-cache view of a
// fetch address for the default cache geometry.
package cpu_types_pkg;

  localparam int WORD_W       = 32;
  localparam int ICACHE_NSETS = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_NSETS);
  localparam int ICACHE_TAG_W = WORD_W - 2 - ICACHE_IDX_W;

  typedef logic [WORD_W-1:0] word_t;

  // Fetch address split as the direct-mapped icache sees it (MSB first)
  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

endpackage

// File: rtl/icache_ctrl.sv
// Direct-mapped, one-word-per-frame instruction cache sitting between the
// datapath fetch port and the memory arbiter. Hits are answered in the same
// cycle; a miss parks the word address and issues a blocking read until the
// memory drops iwait, then the frame is written and the fetch retried.
module icache_ctrl
  import cpu_types_pkg::*;
#(
  parameter int NSETS = 16
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload
);

  localparam int IW = $clog2(NSETS);
  localparam int TW = 30 - IW;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t          state;
  logic [29:0]     miss_addr;
  logic [NSETS-1:0] valid;
  logic [TW-1:0]   tag_arr [NSETS];
  word_t           data_arr [NSETS];

  logic [TW-1:0]   cur_tag;
  logic [IW-1:0]   cur_idx;
  logic [TW-1:0]   fill_tag;
  logic [IW-1:0]   fill_idx;
  logic            hit_now;
  logic            fill_done;
  logic            unused_off;

  assign cur_tag    = imemaddr[31:2+IW];
  assign cur_idx    = imemaddr[1+IW:2];
  assign fill_tag   = miss_addr[29:IW];
  assign fill_idx   = miss_addr[IW-1:0];
  assign unused_off = ^imemaddr[1:0];
  assign fill_done  = (state == FILL) && !iwait && !nRST;

  // Lookup and memory-side request; only IDLE may hit, only FILL may read
  always_comb begin
    hit_now  = (state == IDLE) && imemREN && valid[cur_idx] &&
               (tag_arr[cur_idx] == cur_tag);
    ihit     = hit_now;
    imemload = data_arr[cur_idx];
    iREN     = (state == FILL);
    iaddr    = (state == FILL) ? {miss_addr, 2'b00} : '0;
  end

  // Miss/fill sequencing and valid bits; a reset mid-fill drops the read
  always_ff @(posedge CLK) begin
    if (nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
      valid     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (imemREN && !hit_now) begin
            miss_addr <= imemaddr[31:2];
            state     <= FILL;
          end
        end
        FILL: begin
          if (!iwait) begin
            valid[fill_idx] <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data frames are not reset; they only change when a fill lands
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: a linear fetch sequence with the memory side
// driven by hand, every expected value worked out for NSETS=16.
module tb_icache_ctrl;
  import cpu_types_pkg::*;

  logic  CLK;
  logic  nRST;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  int compared;
  int mismatched;

  icache_ctrl #(.NSETS(16)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  // Free-running 10-unit clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive the fetch port and memory response, then let the logic settle
  task automatic applyStimulus(input logic ren, input logic [31:0] addr,
                               input logic wt, input logic [31:0] ld);
    imemREN  = ren;
    imemaddr = addr;
    iwait    = wt;
    iload    = ld;
    #1;
  endtask

  // One comparison point
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nextEdge();
    @(posedge CLK);
    #1;
  endtask

  // Directed sequence; inputs change at edge+1, outputs checked at edge+2
  initial begin
    compared   = 0;
    mismatched = 0;
    nRST       = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0);
    nextEdge();
    nextEdge();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0);
    checkOutput("rst_ihit", {31'd0, ihit}, 32'd0);
    checkOutput("rst_iren", {31'd0, iREN}, 32'd0);
    checkOutput("rst_iaddr", iaddr, 32'h0);
    nRST = 1'b0;
    nextEdge();

    // Cold miss on 0x40 with three busy cycles
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h0);
    checkOutput("cold_miss_ihit", {31'd0, ihit}, 32'd0);
    checkOutput("cold_miss_iren", {31'd0, iREN}, 32'd0);
    nextEdge();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h40, 1'b1, 32'h0);
      checkOutput("fill_busy_iren", {31'd0, iREN}, 32'd1);
      checkOutput("fill_busy_iaddr", iaddr, 32'h40);
      checkOutput("fill_busy_ihit", {31'd0, ihit}, 32'd0);
      nextEdge();
    end
    applyStimulus(1'b1, 32'h40, 1'b0, 32'h8C220004);
    checkOutput("fill_last_iren", {31'd0, iREN}, 32'd1);
    checkOutput("fill_last_iaddr", iaddr, 32'h40);
    nextEdge();
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h0);
    checkOutput("after_fill_ihit", {31'd0, ihit}, 32'd1);
    checkOutput("after_fill_data", imemload, 32'h8C220004);
    checkOutput("after_fill_iren", {31'd0, iREN}, 32'd0);
    checkOutput("after_fill_iaddr", iaddr, 32'h0);
    nextEdge();

    // Re-fetch with a non-zero byte offset still hits frame 0
    applyStimulus(1'b1, 32'h43, 1'b1, 32'h0);
    checkOutput("refetch_ihit", {31'd0, ihit}, 32'd1);
    checkOutput("refetch_data", imemload, 32'h8C220004);
    checkOutput("refetch_iren", {31'd0, iREN}, 32'd0);
    nextEdge();

    // Conflict: 0x80 shares frame 0 with a different tag
    applyStimulus(1'b1, 32'h80, 1'b1, 32'h0);
    checkOutput("conflict_miss_ihit", {31'd0, ihit}, 32'd0);
    nextEdge();
    applyStimulus(1'b1, 32'h80, 1'b0, 32'h11111111);
    checkOutput("conflict_fill_iren", {31'd0, iREN}, 32'd1);
    checkOutput("conflict_fill_iaddr", iaddr, 32'h80);
    checkOutput("conflict_fill_ihit", {31'd0, ihit}, 32'd0);
    nextEdge();
    applyStimulus(1'b1, 32'h80, 1'b1, 32'h0);
    checkOutput("conflict_hit_ihit", {31'd0, ihit}, 32'd1);
    checkOutput("conflict_hit_data", imemload, 32'h11111111);
    nextEdge();
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h0);
    checkOutput("evicted_miss_ihit", {31'd0, ihit}, 32'd0);
    nextEdge();

    // Address changes and request drop during the 0x40 refill
    applyStimulus(1'b0, 32'h44, 1'b1, 32'h0);
    checkOutput("chg_fill_iren", {31'd0, iREN}, 32'd1);
    checkOutput("chg_fill_iaddr", iaddr, 32'h40);
    nextEdge();
    applyStimulus(1'b1, 32'h80, 1'b1, 32'h0);
    checkOutput("fill_blocks_hit", {31'd0, ihit}, 32'd0);
    checkOutput("chg_fill_iaddr2", iaddr, 32'h40);
    nextEdge();
    applyStimulus(1'b1, 32'h44, 1'b0, 32'h8C220004);
    checkOutput("chg_fill_iaddr3", iaddr, 32'h40);
    nextEdge();
    applyStimulus(1'b1, 32'h44, 1'b1, 32'h0);
    checkOutput("miss44_ihit", {31'd0, ihit}, 32'd0);
    checkOutput("miss44_iren", {31'd0, iREN}, 32'd0);
    nextEdge();
    applyStimulus(1'b1, 32'h44, 1'b0, 32'h22222222);
    checkOutput("fill44_iaddr", iaddr, 32'h44);
    nextEdge();
    applyStimulus(1'b1, 32'h44, 1'b1, 32'h0);
    checkOutput("hit44_ihit", {31'd0, ihit}, 32'd1);
    checkOutput("hit44_data", imemload, 32'h22222222);
    nextEdge();
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h0);
    checkOutput("hit40_ihit", {31'd0, ihit}, 32'd1);
    checkOutput("hit40_data", imemload, 32'h8C220004);
    nextEdge();

    // No request: valid frame addressed but nothing may happen
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 32'h40, 1'b1, 32'h0);
      checkOutput("noreq_ihit", {31'd0, ihit}, 32'd0);
      checkOutput("noreq_iren", {31'd0, iREN}, 32'd0);
      checkOutput("noreq_iaddr", iaddr, 32'h0);
      nextEdge();
    end

    // Reset lands on the completing fill cycle of 0x80
    applyStimulus(1'b1, 32'h80, 1'b1, 32'h0);
    checkOutput("pre_rst_miss_ihit", {31'd0, ihit}, 32'd0);
    nextEdge();
    nRST = 1'b1;
    applyStimulus(1'b1, 32'h80, 1'b0, 32'h33333333);
    checkOutput("rst_fill_iren", {31'd0, iREN}, 32'd1);
    nextEdge();
    nRST = 1'b0;
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h0);
    checkOutput("post_rst_iren", {31'd0, iREN}, 32'd0);
    checkOutput("post_rst_iaddr", iaddr, 32'h0);
    checkOutput("post_rst_miss40", {31'd0, ihit}, 32'd0);
    nextEdge();
    applyStimulus(1'b1, 32'h40, 1'b0, 32'h44444444);
    checkOutput("post_rst_fill_iaddr", iaddr, 32'h40);
    nextEdge();
    applyStimulus(1'b1, 32'h80, 1'b1, 32'h0);
    checkOutput("discarded_fill_ihit", {31'd0, ihit}, 32'd0);
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h0);
    checkOutput("post_rst_hit_data", imemload, 32'h44444444);
    checkOutput("post_rst_hit_ihit", {31'd0, ihit}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
